// File: rtl/sample_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fifo_pkg : CSR map and bit indices shared by the sample FIFO. Rev 1.0
// ---------------------------------------------------------------------------
package sample_fifo_pkg;

  localparam logic [2:0] ADDR_FILL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_EVENT   = 3'd2;
  localparam logic [2:0] ADDR_IENABLE = 3'd3;
  localparam logic [2:0] ADDR_AF      = 3'd4;
  localparam logic [2:0] ADDR_AE      = 3'd5;
  localparam logic [2:0] ADDR_CONTROL = 3'd6;

  localparam int EV_W   = 4;
  localparam int EV_OVF = 0;
  localparam int EV_UDF = 1;
  localparam int EV_AE  = 2;
  localparam int EV_AF  = 3;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_DROP  = 1;

  typedef struct packed {
    logic almost_empty;
    logic almost_full;
    logic empty;
    logic full;
  } status_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fifo_mem : DATA_W x DEPTH register array, sync write, async read. Rev 1.0
// ---------------------------------------------------------------------------
module sample_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Contents are never reset; the owner's pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/sample_fifo_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fifo_csr : Avalon-MM write slave to show-ahead stream FIFO with CSRs. Rev 1.0
// ---------------------------------------------------------------------------
module sample_fifo_csr
  import sample_fifo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int AF_DEFAULT = DEPTH - 4,
  parameter int AE_DEFAULT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_writedata,
  input  logic              wr_write,
  output logic              wr_waitrequest,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Previous-condition flags start at the values the conditions take on an
  // empty FIFO, so leaving reset does not fake a rising edge.
  localparam logic [EV_W-1:0] EV_PREV_RST = {(AF_DEFAULT <= 0), 1'b1, 2'b00};

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d, af_q, af_d, ae_q, ae_d;
  logic [EV_W-1:0]  event_q, event_d, ienable_q, ienable_d, ev_prev_q, ev_prev_d;
  logic             drop_q, drop_d, irq_q, irq_d;
  logic [31:0]      csr_rdata_q, csr_rdata_d;

  logic             full, empty, almost_full, almost_empty;
  logic             flush, push, pop;
  logic [EV_W-1:0]  ev_cond, ev_set, ev_clr;
  status_t          status;
  logic             unused_wdata;

  assign unused_wdata = ^csr_writedata;

  sample_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_writedata),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    full         = (level_q == LVL_W'(DEPTH));
    empty        = (level_q == '0);
    almost_full  = (level_q >= af_q);
    almost_empty = (level_q <= ae_q);
    flush        = csr_write && (csr_address == ADDR_CONTROL) && csr_writedata[CTRL_FLUSH];
    push         = wr_write && !full && !flush;
    pop          = !empty && rd_ready && !flush;

    status.almost_empty = almost_empty;
    status.almost_full  = almost_full;
    status.empty        = empty;
    status.full         = full;

    ev_cond         = '0;
    ev_cond[EV_OVF] = drop_q && wr_write && full;
    ev_cond[EV_UDF] = rd_ready && empty;
    ev_cond[EV_AE]  = almost_empty;
    ev_cond[EV_AF]  = almost_full;
    ev_set          = ev_cond & ~ev_prev_q;
    ev_clr          = (csr_write && (csr_address == ADDR_EVENT)) ? csr_writedata[EV_W-1:0] : '0;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    af_d      = af_q;
    ae_d      = ae_q;
    ienable_d = ienable_q;
    drop_d    = drop_q;
    ev_prev_d = ev_cond;
    // Set is OR-ed in after the clear so a coincident set survives.
    event_d   = (event_q & ~ev_clr) | ev_set;
    irq_d     = |(event_q & ienable_q);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end

    if (csr_write) begin
      case (csr_address)
        ADDR_IENABLE: ienable_d = csr_writedata[EV_W-1:0];
        ADDR_AF:      af_d      = csr_writedata[LVL_W-1:0];
        ADDR_AE:      ae_d      = csr_writedata[LVL_W-1:0];
        ADDR_CONTROL: drop_d    = csr_writedata[CTRL_DROP];
        default:      ;
      endcase
    end

    csr_rdata_d = csr_rdata_q;
    if (csr_read) begin
      case (csr_address)
        ADDR_FILL:    csr_rdata_d = 32'(level_q);
        ADDR_STATUS:  csr_rdata_d = 32'(status);
        ADDR_EVENT:   csr_rdata_d = 32'(event_q);
        ADDR_IENABLE: csr_rdata_d = 32'(ienable_q);
        ADDR_AF:      csr_rdata_d = 32'(af_q);
        ADDR_AE:      csr_rdata_d = 32'(ae_q);
        ADDR_CONTROL: csr_rdata_d = 32'({drop_q, 1'b0});
        default:      csr_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      af_q        <= LVL_W'(AF_DEFAULT);
      ae_q        <= LVL_W'(AE_DEFAULT);
      event_q     <= '0;
      ienable_q   <= '0;
      drop_q      <= 1'b0;
      ev_prev_q   <= EV_PREV_RST;
      irq_q       <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      event_q     <= event_d;
      ienable_q   <= ienable_d;
      drop_q      <= drop_d;
      ev_prev_q   <= ev_prev_d;
      irq_q       <= irq_d;
      csr_rdata_q <= csr_rdata_d;
    end
  end

  assign wr_waitrequest = full && !drop_q;
  assign rd_valid       = !empty;
  assign csr_readdata   = csr_rdata_q;
  assign irq            = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_fifo_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sample_fifo_csr : scoreboard bench for sample_fifo_csr (DEPTH=8). Rev 1.0
// ---------------------------------------------------------------------------
module tb_sample_fifo_csr;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] wr_writedata = '0;
  logic              wr_write = 1'b0;
  logic              wr_waitrequest;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [2:0]        csr_address = '0;
  logic              csr_read = 1'b0;
  logic [31:0]       csr_readdata;
  logic              csr_write = 1'b0;
  logic [31:0]       csr_writedata = '0;
  logic              irq;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_rd[$];
  exp_t exp_csr[$];

  sample_fifo_csr #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_writedata   (wr_writedata),
    .wr_write       (wr_write),
    .wr_waitrequest (wr_waitrequest),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Monitor: compares stream pops and CSR read responses against the queues.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready && !reset) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, none expected", rd_data);
        end else begin
          e = exp_rd.pop_front();
          if (32'(rd_data) !== e.v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, rd_data, e.v);
          end
        end
      end
      if (pend) begin
        checks++;
        if (exp_csr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_csr: got 0x%0h, none expected", csr_readdata);
        end else begin
          e = exp_csr.pop_front();
          if (csr_readdata !== e.v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, csr_readdata, e.v);
          end
        end
      end
      @(posedge clk);
      pend = csr_read && !reset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    wr_writedata = d;
    wr_write     = 1'b1;
    while (wr_waitrequest && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("push_timeout", 32'(wr_waitrequest), 32'd0);
    tick();
    wr_write = 1'b0;
  endtask

  task automatic pop_exp(input string nm, input logic [31:0] d);
    exp_t e;
    e.nm = nm;
    e.v  = d;
    exp_rd.push_back(e);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input string nm, input logic [2:0] a, input logic [31:0] d);
    exp_t e;
    e.nm = nm;
    e.v  = d;
    exp_csr.push_back(e);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read = 1'b0;
  endtask

  initial begin : stim
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state: STATUS = {ae=1, af=0, empty=1, full=0}
    chk("rst_readdata", csr_readdata, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    csr_rd("rst_fill", 3'd0, 32'd0);
    csr_rd("rst_status", 3'd1, 32'hA);
    csr_rd("rst_ienable", 3'd3, 32'd0);
    csr_rd("rst_af", 3'd4, 32'd4);
    csr_rd("rst_ae", 3'd5, 32'd4);
    csr_rd("rst_control", 3'd6, 32'd0);
    csr_rd("reserved", 3'd7, 32'd0);

    // Basic show-ahead ordering
    push(16'h11); push(16'h22); push(16'h33);
    csr_rd("t1_fill3", 3'd0, 32'd3);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_head", 32'(rd_data), 32'h11);
    pop_exp("t1_pop0", 32'h11);
    pop_exp("t1_pop1", 32'h22);
    pop_exp("t1_pop2", 32'h33);
    chk("t1_empty_valid", 32'(rd_valid), 32'd0);
    csr_rd("t1_fill0", 3'd0, 32'd0);

    // Stall mode: 9th write held until a pop frees a slot
    for (int i = 1; i <= 8; i++) push(DATA_W'(i));
    chk("t2_wait_full", 32'(wr_waitrequest), 32'd1);
    csr_rd("t2_status_full", 3'd1, 32'h5);
    wr_writedata = 16'd9;
    wr_write     = 1'b1;
    tick(); tick();
    chk("t2_wait_held", 32'(wr_waitrequest), 32'd1);
    pop_exp("t2_pop1", 32'd1);
    chk("t2_wait_freed", 32'(wr_waitrequest), 32'd0);
    tick();
    wr_write = 1'b0;
    csr_rd("t2_fill8", 3'd0, 32'd8);
    chk("t2_wait_again", 32'(wr_waitrequest), 32'd1);
    for (int i = 2; i <= 9; i++) pop_exp("t2_drain", 32'(i));

    // Drop mode overflow, event, irq and W1C
    csr_wr(3'd6, 32'h2);
    csr_rd("t3_control", 3'd6, 32'h2);
    for (int i = 0; i < 8; i++) push(DATA_W'(16'h40 + i));
    chk("t3_nowait", 32'(wr_waitrequest), 32'd0);
    csr_wr(3'd2, 32'hF);
    csr_rd("t3_ev_clear", 3'd2, 32'h0);
    csr_wr(3'd3, 32'h1);
    push(16'hAA);
    csr_rd("t3_ev_ovf", 3'd2, 32'h1);
    chk("t3_irq_set", 32'(irq), 32'd1);
    csr_rd("t3_fill8", 3'd0, 32'd8);
    csr_wr(3'd2, 32'h1);
    tick();
    chk("t3_irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) pop_exp("t3_drain", 32'h40 + 32'(i));
    chk("t3_no_aa", 32'(rd_valid), 32'd0);
    csr_wr(3'd6, 32'h0);

    // Almost-full rising edge is sticky; re-crossing changes nothing
    csr_wr(3'd2, 32'hF);
    csr_wr(3'd4, 32'd6);
    csr_wr(3'd3, 32'h8);
    csr_rd("t4_af", 3'd4, 32'd6);
    for (int i = 0; i < 5; i++) push(DATA_W'(16'h50 + i));
    csr_rd("t4_ev_lvl5", 3'd2, 32'h0);
    chk("t4_irq_lvl5", 32'(irq), 32'd0);
    push(16'h55);
    tick(); tick();
    chk("t4_irq_lvl6", 32'(irq), 32'd1);
    csr_rd("t4_ev_af", 3'd2, 32'h8);
    csr_rd("t4_status", 3'd1, 32'h4);
    pop_exp("t4_pop", 32'h50);
    push(16'h56);
    csr_rd("t4_ev_again", 3'd2, 32'h8);
    chk("t4_irq_again", 32'(irq), 32'd1);
    for (int i = 1; i <= 6; i++) pop_exp("t4_drain", 32'h50 + 32'(i));
    csr_wr(3'd2, 32'hF);
    csr_wr(3'd3, 32'h0);
    tick();
    chk("t4_irq_off", 32'(irq), 32'd0);

    // Flush wins over a same-cycle push
    for (int i = 0; i < 5; i++) push(DATA_W'(16'h60 + i));
    wr_writedata  = 16'h99;
    wr_write      = 1'b1;
    csr_address   = 3'd6;
    csr_writedata = 32'h1;
    csr_write     = 1'b1;
    tick();
    wr_write  = 1'b0;
    csr_write = 1'b0;
    csr_rd("t5_fill0", 3'd0, 32'd0);
    chk("t5_valid", 32'(rd_valid), 32'd0);
    csr_rd("t5_control", 3'd6, 32'h0);
    push(16'h77);
    chk("t5_head", 32'(rd_data), 32'h77);
    pop_exp("t5_pop", 32'h77);

    // Underflow, then sustained push+pop across the pointer wrap
    csr_wr(3'd2, 32'hF);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    csr_rd("t6_ev_udf", 3'd2, 32'h2);
    csr_rd("t6_fill0", 3'd0, 32'd0);
    for (int i = 0; i < 4; i++) push(DATA_W'(16'h80 + i));
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.nm = "t6_stream";
      e.v  = 32'h80 + 32'(i);
      exp_rd.push_back(e);
      wr_writedata = DATA_W'(16'h84 + i);
      wr_write     = 1'b1;
      rd_ready     = 1'b1;
      tick();
    end
    wr_write = 1'b0;
    rd_ready = 1'b0;
    csr_rd("t6_fill4", 3'd0, 32'd4);
    for (int i = 0; i < 4; i++) pop_exp("t6_drain", 32'h8A + 32'(i));

    // Reset mid-burst discards contents and restores defaults
    push(16'hC1); push(16'hC2); push(16'hC3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_valid", 32'(rd_valid), 32'd0);
    chk("t7_readdata", csr_readdata, 32'h0);
    csr_rd("t7_fill", 3'd0, 32'd0);
    csr_rd("t7_af", 3'd4, 32'd4);

    repeat (3) tick();
    while (exp_rd.size() > 0) begin
      exp_t e;
      e = exp_rd.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no pop expected 0x%0h", e.nm, e.v);
    end
    while (exp_csr.size() > 0) begin
      exp_t e;
      e = exp_csr.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no response expected 0x%0h", e.nm, e.v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_fifo_csr.md
Name: sample_fifo_csr

Overview:
Parametrised successor to the single-instance sample FIFO in the Qsys system. It is an Avalon-MM write slave feeding a show-ahead stream output, with an Avalon-MM CSR port and an interrupt line.
- Adds over the current FIFO: configurable data width and depth, programmable almost-full/almost-empty thresholds, sticky W1C events, a per-event IRQ mask, flush, and a drop-on-full mode.
- Sits between the HPS write path and audio/VGA sample consumers.

Parameters:
DATA_W, 32, sample word width (1..32)
DEPTH, 256, FIFO depth in words; power of 2, ≥4
AF_DEFAULT, DEPTH-4, reset value of almost-full threshold
AE_DEFAULT, 4, reset value of almost-empty threshold

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
wr_writedata  in  DATA_W  sample to push
wr_write  in  1  write strobe
wr_waitrequest  out  1  write stall
rd_data  out  DATA_W  head-of-FIFO word (show-ahead)
rd_valid  out  1  head word valid
rd_ready  in  1  consumer accepts head
csr_address  in  3  CSR word address
csr_read  in  1  CSR read strobe
csr_readdata  out  32  CSR read data, 1-cycle latency
csr_write  in  1  CSR write strobe
csr_writedata  in  32  CSR write data
irq  out  1  level interrupt

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - pointers, level, EVENT, IENABLE and CONTROL are 0;
  - AF = AF_DEFAULT, AE = AE_DEFAULT;
  - rd_valid = 0, irq = 0, csr_readdata = 0;
  - a reset mid-burst discards all contents.
- Level: LVL_W = $clog2(DEPTH)+1 bits. full = (level == DEPTH), empty = (level == 0).
- Push: accepted when wr_write & !full & !flush_this_cycle.
- Stall mode (CONTROL[1] = 0): wr_waitrequest = full (combinational). The master holds the write until it is accepted.
- Drop mode (CONTROL[1] = 1): wr_waitrequest = 0. A write while full is discarded and sets EVENT[0] (overflow).
- Pop: occurs when rd_valid & rd_ready. rd_valid = !empty. rd_data is the head word, combinational from memory; it is don't-care when !rd_valid.
- Simultaneous push and pop: level is unchanged and both pointers advance. Full is sampled at the start of the cycle, so a write while full is not accepted even if a pop happens that cycle.
- Pointers: wrap modulo DEPTH.
- Flush (write CONTROL[0] = 1):
  - pointers and level are 0 on the next cycle;
  - any same-cycle push or pop is ignored;
  - the bit self-clears and reads back 0;
  - EVENT is not cleared.
- Conditions: almost_full = (level ≥ AF); almost_empty = (level ≤ AE).
- EVENT bits are sticky and set on the condition's rising edge (registered previous value):
  - [0] overflow (drop mode only)
  - [1] underflow: rd_ready while empty
  - [2] almost_empty rising
  - [3] almost_full rising
- Clearing EVENT: write 1 to a bit to clear it. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq: registered, irq = |(EVENT & IENABLE), one cycle after EVENT updates.
- CSR map (word addresses; unused bits read 0; writes to RO registers are ignored):
  - 0 FILL RO: level
  - 1 STATUS RO: {almost_empty, almost_full, empty, full} in bits [3:0]
  - 2 EVENT W1C: [3:0]
  - 3 IENABLE RW: [3:0]
  - 4 AF RW: [LVL_W-1:0]
  - 5 AE RW: [LVL_W-1:0]
  - 6 CONTROL: bit0 flush (W, self-clearing), bit1 drop_mode (RW)
  - 7 reserved: reads 0
- CSR read: csr_readdata is registered, valid the cycle after csr_read, and holds its value otherwise. The value reflects state before any same-cycle CSR write.

Decomposition:
- Package sample_fifo_pkg holds:
  - CSR address localparams (ADDR_FILL .. ADDR_CONTROL);
  - EVENT bit indices (EV_OVF, EV_UDF, EV_AE, EV_AF);
  - CONTROL bit indices.
- One sub-module, sample_fifo_mem: simple dual-port register array with one synchronous write port and a combinational read address, DATA_W × DEPTH.
- Pointers, level, CSR and IRQ logic stay in the top module.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 with rd_ready = 0 → FILL = 3, rd_valid = 1, rd_data = 0x11. Then pop 3 → data in order 0x11, 0x22, 0x33, then rd_valid = 0, FILL = 0.
2. DEPTH = 8, stall mode, push 9 words → waitrequest = 1 after the 8th is accepted, 9th stalls. Assert rd_ready for 1 cycle → 9th accepted the next cycle, FILL = 8.
3. Drop mode, DEPTH = 8, fill and push 0xAA → word dropped, EVENT = 0x1. With IENABLE = 0x1, irq = 1; write EVENT = 0x1 → irq = 0 within 2 cycles.
4. AF = 6, IENABLE = 0x8, push 6 words → EVENT[3] set at level 6, irq asserted. Pop to 5 and push to 6 again without clearing → no additional effect, bit stays 1.
5. FIFO at level 5 with wr_write in the same cycle as a CONTROL = 0x1 write → FILL = 0 next cycle, rd_valid = 0, CONTROL reads 0x0.
6. Empty FIFO, rd_ready = 1 → EVENT[1] set, level stays 0. Simultaneous push+pop at level 4 for 10 cycles → FILL stays 4, pointers wrap correctly (DEPTH = 8).
